// File: rtl/mul_sequencer.sv
// Control sequencer for the shift-add multiplier: LOAD, then WIDTH ADD/SHIFT rounds, then a one-cycle DONE.
// Optional two's-complement multiplier support is built in when MUL_SIGNED_EN is defined.
module mul_sequencer #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             M,
`ifdef MUL_SIGNED_EN
  input  logic             Signed,
  output logic             Sub,
  output logic             ShArith,
`endif
  output logic             Load,
  output logic             Ad,
  output logic             Sh,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_nx;
  logic             active;

  assign active = (state == LOAD) || (state == ADD) || (state == SHIFT);

  // Next state and next round count; Abort only cancels work that is actually in flight.
  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    case (state)
      IDLE:  if (Start) state_nx = LOAD;
      LOAD: begin
        state_nx   = ADD;
        counter_nx = CNT_W'(WIDTH);
      end
      ADD:   state_nx = SHIFT;
      SHIFT: begin
        counter_nx = counter - CNT_W'(1);
        state_nx   = (counter == CNT_W'(1)) ? DONE : ADD;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (Abort && active) begin
      state_nx   = IDLE;
      counter_nx = '0;
    end
  end

  // State, counter and the Moore outputs registered from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      counter <= '0;
      Load    <= 1'b0;
      Sh      <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nx;
      counter <= counter_nx;
      Load    <= (state_nx == LOAD);
      Sh      <= (state_nx == SHIFT);
      Busy    <= (state_nx == LOAD) || (state_nx == ADD) || (state_nx == SHIFT);
      Done    <= (state_nx == DONE);
    end
  end

  assign Cnt = counter;

`ifdef MUL_SIGNED_EN
  logic signed_q;
  logic final_sub;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      signed_q <= 1'b0;
      ShArith  <= 1'b0;
    end else begin
      if (state == LOAD) signed_q <= Signed;
      ShArith <= (state_nx == SHIFT) && signed_q;
    end
  end

  // The multiplier MSB carries negative weight, so its round subtracts instead of adding.
  assign final_sub = (state == ADD) && M && signed_q && (counter == CNT_W'(1));
  assign Sub       = final_sub;
  assign Ad        = (state == ADD) && M && !final_sub;
`else
  // Ad depends on the live ACC[0], which only settles after the edge that enters ADD.
  assign Ad = (state == ADD) && M;
`endif

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: behavioural ACC datapath, vector table and scoreboard of expected results.
// Define MUL_SIGNED_EN on both files to include the signed-multiplier case.
module tb_mul_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int          LAT   = 2 * WIDTH + 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             m;
  logic             load;
  logic             ad;
  logic             sh;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;
  logic             sub;
  logic             sh_arith;
  logic             sgn;

  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] mp_r;
  logic [WIDTH-1:0] mc_r;
  logic [WIDTH:0]   ext;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    int                 ads;
    int                 done_cyc;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0]   mp;
    logic [WIDTH-1:0]   mc;
    logic [2*WIDTH-1:0] prod;
    int                 ads;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];

  int n_vec;
  int n_err;
  int cyc;
  int load_cyc;
  int ad_n;
  int sh_n;
  int busy_n;
  int sub_n;
  int sub_round;
  int sha_n;

  mul_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk    (clk),
    .Reset  (rst),
    .Start  (start),
    .Abort  (abort),
    .M      (m),
`ifdef MUL_SIGNED_EN
    .Signed (sgn),
    .Sub    (sub),
    .ShArith(sh_arith),
`endif
    .Load   (load),
    .Ad     (ad),
    .Sh     (sh),
    .Busy   (busy),
    .Done   (done),
    .Cnt    (cnt)
  );

`ifndef MUL_SIGNED_EN
  assign sub      = 1'b0;
  assign sh_arith = 1'b0;
  assign sgn      = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier datapath driven by the sequencer outputs.
  assign ext = sgn ? {mc_r[WIDTH-1], mc_r} : {1'b0, mc_r};
  assign m   = acc[0];

  always @(posedge clk) begin
    if (rst)       acc <= '0;
    else if (load) acc <= {(WIDTH+1)'(0), mp_r};
    else if (ad)   acc <= {acc[2*WIDTH:WIDTH] + ext, acc[WIDTH-1:0]};
    else if (sub)  acc <= {acc[2*WIDTH:WIDTH] - ext, acc[WIDTH-1:0]};
    else if (sh)   acc <= {sh_arith & acc[2*WIDTH], acc[2*WIDTH:1]};
  end

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic new_test();
    cyc      = 0;
    load_cyc = -100;
  endtask

  // Advance one cycle, sample at the falling edge, track pulses and score any Done.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    chk("ctl_exclusive", (int'(load) + int'(ad) + int'(sh) <= 1) ? 1 : 0, 1);
    if (load) begin
      load_cyc  = cyc;
      ad_n      = 0;
      sh_n      = 0;
      busy_n    = 0;
      sub_n     = 0;
      sub_round = 0;
      sha_n     = 0;
    end
    if (ad) ad_n++;
    if (sh) sh_n++;
    if (sh && sh_arith) sha_n++;
    if (sub) begin
      sub_n++;
      sub_round = sh_n + 1;
    end
    if (busy) busy_n++;
    if (cyc == load_cyc + 1) chk("cnt_init", int'(cnt), WIDTH);
    if (done) begin
      chk("done_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("product", int'(acc[2*WIDTH-1:0]), int'(e.prod));
        chk("ad_pulses", ad_n, e.ads);
        chk("sh_pulses", sh_n, WIDTH);
        chk("busy_cycles", busy_n, 2 * WIDTH + 1);
        chk("done_cycle", cyc, e.done_cyc);
        chk("load_cycle", load_cyc, e.done_cyc - LAT + 1);
        chk("busy_at_done", int'(busy), 0);
        chk("cnt_at_done", int'(cnt), 0);
      end
    end
  endtask

  // Raise Start in the current cycle and record the expected outcome.
  task automatic go(input logic [WIDTH-1:0] mp, input logic [WIDTH-1:0] mc,
                    input logic [2*WIDTH-1:0] prod, input int ads, input bit hold);
    mp_r  = mp;
    mc_r  = mc;
    start = 1'b1;
    sb.push_back('{prod, ads, cyc + LAT});
    step();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mp_r  = '0;
    mc_r  = '0;
`ifdef MUL_SIGNED_EN
    sgn   = 1'b0;
`endif
    ad_n = 0; sh_n = 0; busy_n = 0; sub_n = 0; sub_round = 0; sha_n = 0;
    new_test();

    vt[0] = '{4'd11, 4'd13, 8'd143, 3};
    vt[1] = '{4'd0,  4'd15, 8'd0,   0};
    vt[2] = '{4'd15, 4'd15, 8'd225, 4};
    vt[3] = '{4'd1,  4'd1,  8'd1,   1};
    vt[4] = '{4'd9,  4'd6,  8'd54,  2};
    vt[5] = '{4'd15, 4'd0,  8'd0,   4};
    vt[6] = '{4'd10, 4'd12, 8'd120, 2};
    vt[7] = '{4'd8,  4'd15, 8'd120, 1};

    repeat (2) @(negedge clk);
    chk("reset_ctl", int'({load, ad, sh, busy, done}), 0);
    chk("reset_cnt", int'(cnt), 0);
    rst = 1'b0;
    step();

    foreach (vt[i]) begin
      new_test();
      go(vt[i].mp, vt[i].mc, vt[i].prod, vt[i].ads, 1'b0);
      wait_done(4 * LAT);
      repeat (2) step();
    end

    // Start and Abort together in IDLE: the operation must still run to completion.
    new_test();
    abort = 1'b1;
    go(4'd6, 4'd7, 8'd42, 2, 1'b0);
    abort = 1'b0;
    wait_done(4 * LAT);
    repeat (2) step();

    // Start held high: back-to-back operations separated by one IDLE cycle.
    new_test();
    go(4'd11, 4'd13, 8'd143, 3, 1'b1);
    sb.push_back('{8'd143, 3, 2 * LAT + 1});
    while (cyc < 2 * LAT + 1 && cyc < 100) step();
    start = 1'b0;
    wait_done(4 * LAT);
    repeat (2) step();

    // Abort in a SHIFT cycle, then restart later.
    new_test();
    go(4'd7, 4'd9, 8'd63, 3, 1'b0);
    while (cyc < 5) step();
    chk("sh_in_abort_cycle", int'(sh), 1);
    abort = 1'b1;
    sb.delete();
    step();
    abort = 1'b0;
    chk("abort_ctl", int'({load, ad, sh, busy, done}), 0);
    chk("abort_cnt", int'(cnt), 0);
    while (cyc < 8) step();
    go(4'd7, 4'd9, 8'd63, 3, 1'b0);
    wait_done(4 * LAT);
    repeat (2) step();

    // Synchronous reset in the middle of an operation.
    new_test();
    go(4'd11, 4'd13, 8'd143, 3, 1'b0);
    while (cyc < 4) step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    chk("midop_reset_ctl", int'({load, ad, sh, busy, done}), 0);
    chk("midop_reset_cnt", int'(cnt), 0);
    repeat (14) step();
    new_test();
    go(4'd5, 4'd3, 8'd15, 2, 1'b0);
    wait_done(4 * LAT);
    repeat (2) step();

`ifdef MUL_SIGNED_EN
    // -3 x 5 with a signed multiplier: rounds 1 and 3 add, round 4 subtracts.
    new_test();
    sgn = 1'b1;
    go(4'b1101, 4'd5, 8'hF1, 2, 1'b0);
    wait_done(4 * LAT);
    chk("sub_pulses", sub_n, 1);
    chk("sub_round", sub_round, WIDTH);
    chk("sharith_pulses", sha_n, WIDTH);
    sgn = 1'b0;
    repeat (2) step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
